// File: rtl/fifo_word_packer.sv
// Pops DSIZE-bit entries from a show-ahead async FIFO read port and packs WORD_BYTES of them per valid/ready word.
// Optional partial-word flush after TIMEOUT idle cycles is enabled by defining FLUSH_TIMEOUT_EN.
module fifo_word_packer #(
   parameter int unsigned DSIZE      = 8,
   parameter int unsigned WORD_BYTES = 4,
   parameter int unsigned TIMEOUT    = 16
) (
   input  logic                          rclk,
   input  logic                          rrst_n,
   input  logic [DSIZE-1:0]              fifo_rdata,
   input  logic                          fifo_rempty,
   output logic                          fifo_rinc,
   output logic [DSIZE*WORD_BYTES-1:0]   m_data,
   output logic [WORD_BYTES-1:0]         m_keep,
   output logic                          m_valid,
   input  logic                          m_ready
);

   localparam int unsigned WW = DSIZE * WORD_BYTES;
   localparam int unsigned CW = $clog2(WORD_BYTES + 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(WORD_BYTES);

   // Elaboration-time parameter range guard
   if (WORD_BYTES < 2 || WORD_BYTES > 8 || TIMEOUT < 1 || TIMEOUT > 255 || DSIZE < 1) begin : g_bad_param
      $error("fifo_word_packer: parameter out of range");
   end

   logic [WW-1:0]         acc;
   logic [WW-1:0]         acc_nxt;
   logic [CW-1:0]         cnt;
   logic [CW-1:0]         cnt_nxt;
   logic [WORD_BYTES-1:0] lane_mask;
   logic                  flush_pend;
   logic                  acc_full;
   logic                  xfer;
   logic                  pop;

`ifdef FLUSH_TIMEOUT_EN
   localparam int unsigned TW = 8;
   logic [TW-1:0] timer;

   assign flush_pend = (timer == TW'(TIMEOUT));

   // Idle timer: runs only while a partial word waits with no pop, saturates at TIMEOUT
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         timer <= '0;
      end else if (pop || xfer) begin
         timer <= '0;
      end else if ((cnt != '0) && (cnt < CNT_FULL) && !flush_pend) begin
         timer <= timer + TW'(1);
      end
   end

   always_comb begin
      lane_mask = '0;
      for (int i = 0; i < int'(WORD_BYTES); i++) begin
         lane_mask[i] = (CW'(i) < cnt);
      end
   end
`else
   assign flush_pend = 1'b0;
   assign lane_mask  = '1;
`endif

   assign acc_full  = (cnt == CNT_FULL) || flush_pend;
   assign xfer      = acc_full && (!m_valid || m_ready);
   // A pending flush blocks pops so the partial word leaves before new bytes land
   assign pop       = rrst_n && !fifo_rempty && (((cnt < CNT_FULL) && !flush_pend) || xfer);
   assign fifo_rinc = pop;

   // Next accumulator: xfer empties it first, so a same-cycle pop lands in lane 0
   always_comb begin
      acc_nxt = acc;
      cnt_nxt = cnt;
      if (xfer) begin
         acc_nxt = '0;
         cnt_nxt = '0;
      end
      if (pop) begin
         for (int i = 0; i < int'(WORD_BYTES); i++) begin
            if (CW'(i) == cnt_nxt) begin
               acc_nxt[i*DSIZE +: DSIZE] = fifo_rdata;
            end
         end
         cnt_nxt = cnt_nxt + CW'(1);
      end
   end

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         acc <= '0;
         cnt <= '0;
      end else begin
         acc <= acc_nxt;
         cnt <= cnt_nxt;
      end
   end

   // Output register holds its word until accepted
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         m_data  <= '0;
         m_keep  <= '0;
         m_valid <= 1'b0;
      end else if (xfer) begin
         m_data  <= acc;
         m_keep  <= lane_mask;
         m_valid <= 1'b1;
      end else if (m_ready) begin
         m_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer: behavioural show-ahead FIFO feeding the DUT, scoreboard of expected words.
module tb_fifo_word_packer;

   localparam int unsigned DSIZE   = 8;
   localparam int unsigned WB      = 4;
   localparam int unsigned TIMEOUT = 16;
   localparam int unsigned WW      = DSIZE * WB;
   localparam int          DEPTH   = 16;

   logic             rclk = 1'b0;
   logic             rrst_n;
   logic [DSIZE-1:0] fifo_rdata;
   logic             fifo_rempty;
   logic             fifo_rinc;
   logic [WW-1:0]    m_data;
   logic [WB-1:0]    m_keep;
   logic             m_valid;
   logic             m_ready;

   fifo_word_packer #(.DSIZE(DSIZE), .WORD_BYTES(WB), .TIMEOUT(TIMEOUT)) dut (
      .rclk(rclk), .rrst_n(rrst_n), .fifo_rdata(fifo_rdata), .fifo_rempty(fifo_rempty),
      .fifo_rinc(fifo_rinc), .m_data(m_data), .m_keep(m_keep), .m_valid(m_valid), .m_ready(m_ready)
   );

   always #5 rclk = ~rclk;

   typedef struct packed {
      logic [WW-1:0] data;
      logic [WB-1:0] keep;
   } exp_t;

   typedef struct {
      logic [7:0]    base;
      int            n;
      int            rmode;
      int            exp_words;
      logic [WW-1:0] exp_last;
   } vec_t;

   exp_t       expq[$];
   logic [7:0] src[$];
   logic [7:0] fq[$];
   logic [7:0] part[$];

   int            errors = 0;
   int            checks = 0;
   int            ready_mode = 0;
   int            words_seen = 0;
   int            pops = 0;
   int            empty_pops = 0;
   int            bubbles = 0;
   logic [WW-1:0] last_word = '0;
   logic          prev_hold = 1'b0;
   logic [WW-1:0] prev_data = '0;
   logic [WB-1:0] prev_keep = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference packer: every WB written bytes form one expected word, first byte in lane 0
   task automatic write_bytes(input logic [7:0] base, input int n);
      logic [WW-1:0] w;
      for (int i = 0; i < n; i++) begin
         logic [7:0] b;
         b = base + 8'(i);
         src.push_back(b);
         part.push_back(b);
         if (part.size() == WB) begin
            w = '0;
            for (int k = 0; k < int'(WB); k++) w[k*DSIZE +: DSIZE] = part[k];
            expq.push_back('{data: w, keep: 4'hF});
            part.delete();
         end
      end
   endtask

   task automatic step();
      logic p;
      exp_t e;
      @(negedge rclk);
      if (src.size() > 0 && fq.size() < DEPTH) fq.push_back(src.pop_front());
      fifo_rempty = (fq.size() == 0);
      fifo_rdata  = fifo_rempty ? 8'h00 : fq[0];
      case (ready_mode)
         0:       m_ready = 1'b1;
         1:       m_ready = 1'($urandom_range(0, 1));
         default: m_ready = 1'b0;
      endcase
      #1;
      if (prev_hold) begin
         check("hold_valid", 64'(m_valid), 64'd1);
         check("hold_data_keep", 64'({m_keep, m_data}), 64'({prev_keep, prev_data}));
      end
      p = fifo_rinc;
      if (p && fifo_rempty) empty_pops++;
      if (!fifo_rempty && !p) bubbles++;
      if (m_valid && m_ready) begin
         words_seen++;
         last_word = m_data;
         if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %0h expected none", m_data);
         end else begin
            e = expq.pop_front();
            check("word_data", 64'(m_data), 64'(e.data));
            check("word_keep", 64'(m_keep), 64'(e.keep));
         end
      end
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
      prev_keep = m_keep;
      @(posedge rclk);
      if (p) begin
         pops++;
         if (fq.size() > 0) void'(fq.pop_front());
      end
   endtask

   task automatic run_until_idle(input int budget);
      bit done;
      done = 1'b0;
      for (int c = 0; c < budget && !done; c++) begin
         step();
         done = (src.size() == 0) && (fq.size() == 0) && (expq.size() == 0) && !m_valid;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d words pending expected 0", expq.size());
      end
   endtask

   task automatic do_reset();
      @(negedge rclk);
      rrst_n = 1'b0;
      src.delete(); fq.delete(); expq.delete(); part.delete();
      prev_hold   = 1'b0;
      fifo_rempty = 1'b0;
      fifo_rdata  = 8'hEE;
      m_ready     = 1'b1;
      for (int c = 0; c < 2; c++) begin
         #1;
         check("rst_valid", 64'(m_valid), 64'd0);
         check("rst_rinc", 64'(fifo_rinc), 64'd0);
         @(negedge rclk);
      end
      rrst_n      = 1'b1;
      fifo_rempty = 1'b1;
   endtask

   vec_t tbl[4];

   initial begin
      tbl[0] = '{base: 8'h01, n: 8,  rmode: 0, exp_words: 2,  exp_last: 32'h08070605};
      tbl[1] = '{base: 8'h01, n: 64, rmode: 0, exp_words: 16, exp_last: 32'h403F3E3D};
      tbl[2] = '{base: 8'h41, n: 64, rmode: 1, exp_words: 16, exp_last: 32'h807F7E7D};
      tbl[3] = '{base: 8'hA0, n: 12, rmode: 0, exp_words: 3,  exp_last: 32'hABAAA9A8};

      rrst_n      = 1'b0;
      m_ready     = 1'b1;
      fifo_rempty = 1'b1;
      fifo_rdata  = '0;
      #1;
      check("reset_valid", 64'(m_valid), 64'd0);
      check("reset_data", 64'(m_data), 64'd0);
      check("reset_keep", 64'(m_keep), 64'd0);
      check("reset_rinc", 64'(fifo_rinc), 64'd0);
      repeat (2) @(negedge rclk);
      rrst_n = 1'b1;

      // Table-driven streaming scenarios
      for (int t = 0; t < 4; t++) begin
         ready_mode = tbl[t].rmode;
         words_seen = 0; empty_pops = 0; bubbles = 0;
         write_bytes(tbl[t].base, tbl[t].n);
         run_until_idle(600);
         check($sformatf("vec%0d_words", t), 64'(words_seen), 64'(tbl[t].exp_words));
         check($sformatf("vec%0d_last", t), 64'(last_word), 64'(tbl[t].exp_last));
         check($sformatf("vec%0d_empty_pop", t), 64'(empty_pops), 64'd0);
         if (tbl[t].rmode == 0) check($sformatf("vec%0d_bubbles", t), 64'(bubbles), 64'd0);
      end

      // Backpressure: one word parks in the output register, the accumulator fills, then pops stop
      ready_mode = 2;
      pops = 0; words_seen = 0;
      write_bytes(8'h01, 16);
      repeat (40) step();
      check("bp_pops", 64'(pops), 64'd8);
      check("bp_fifo_level", 64'(fq.size()), 64'd8);
      check("bp_rinc", 64'(fifo_rinc), 64'd0);
      check("bp_valid", 64'(m_valid), 64'd1);
      check("bp_data", 64'(m_data), 64'h04030201);
      ready_mode = 0;
      run_until_idle(200);
      check("bp_words", 64'(words_seen), 64'd4);
      check("bp_last", 64'(last_word), 64'h100F0E0D);

      // Partial word: flushed after the idle timeout only when the feature is built in
      words_seen = 0;
      write_bytes(8'h01, 6);
`ifdef FLUSH_TIMEOUT_EN
      expq.push_back('{data: 32'h00000605, keep: 4'h3});
      repeat (60) step();
      check("partial_words", 64'(words_seen), 64'd2);
      check("partial_last", 64'(last_word), 64'h00000605);
`else
      repeat (60) step();
      check("partial_words", 64'(words_seen), 64'd1);
      check("partial_last", 64'(last_word), 64'h04030201);
`endif
      check("partial_pending", 64'(expq.size()), 64'd0);

      // Reset mid-word discards the stale bytes
      do_reset();
      write_bytes(8'h01, 3);
      repeat (6) step();
      do_reset();
      words_seen = 0;
      write_bytes(8'h11, 4);
      run_until_idle(100);
      repeat (10) step();
      check("rst_words", 64'(words_seen), 64'd1);
      check("rst_last", 64'(last_word), 64'h14131211);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
